// File: rtl/demux_1to4_pkg.sv
// -----------------------------------------------------------------------------
// demux_1to4_pkg
//   Shared constants, select-code names and the select-to-enable helper used by
//   the 1-to-4 demultiplexer and its core.
// -----------------------------------------------------------------------------
package demux_1to4_pkg;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned SEL_W   = 2;

    // Names for the four select codes; the value equals the output index minus one.
    typedef enum logic [SEL_W-1:0] {
        SEL_OUT1 = 2'b00,
        SEL_OUT2 = 2'b01,
        SEL_OUT3 = 2'b10,
        SEL_OUT4 = 2'b11
    } sel_e;

    // One-hot enable: bit N is set when output N+1 is selected.
    function automatic logic [NUM_OUT-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] one;
        one = {{(NUM_OUT-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/demux_1to4_core.sv
// -----------------------------------------------------------------------------
// demux_1to4_core
//   Combinational select decoder plus AND gating. The selected output carries
//   a; every other output is zero.
// Ports
//   a    in   WIDTH  data to route
//   sel  in   2      select code {s1,s0}
//   y0   out  WIDTH  a when sel = 2'b00, else 0
//   y1   out  WIDTH  a when sel = 2'b01, else 0
//   y2   out  WIDTH  a when sel = 2'b10, else 0
//   y3   out  WIDTH  a when sel = 2'b11, else 0
// -----------------------------------------------------------------------------
module demux_1to4_core
    import demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3
);

    logic [NUM_OUT-1:0] en;

    always_comb begin
        en = sel_to_onehot(sel);
        y0 = en[0] ? a : '0;
        y1 = en[1] ? a : '0;
        y2 = en[2] ? a : '0;
        y3 = en[3] ? a : '0;
    end

endmodule

// File: rtl/demux_1to4.sv
// -----------------------------------------------------------------------------
// demux_1to4
//   1-to-4 demultiplexer. Routes a to the output selected by {s1,s0}; the
//   unselected outputs are zero. With REG_OUT=1 the outputs are registered
//   (one cycle latency, synchronous active-high reset clears them); with
//   REG_OUT=0 they are purely combinational and clk/rst are ignored.
// Ports
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous active-high reset (registered mode only)
//   a     in   WIDTH  data to route
//   s0    in   1      select LSB
//   s1    in   1      select MSB
//   out1  out  WIDTH  a when {s1,s0}=00, else 0
//   out2  out  WIDTH  a when {s1,s0}=01, else 0
//   out3  out  WIDTH  a when {s1,s0}=10, else 0
//   out4  out  WIDTH  a when {s1,s0}=11, else 0
// -----------------------------------------------------------------------------
module demux_1to4
    import demux_1to4_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4
);

    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;

    demux_1to4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a),
        .sel ({s1, s0}),
        .y0  (y0),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3)
    );

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                out1 <= '0;
                out2 <= '0;
                out3 <= '0;
                out4 <= '0;
            end else begin
                out1 <= y0;
                out2 <= y1;
                out3 <= y2;
                out4 <= y3;
            end
        end
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign out1 = y0;
        assign out2 = y1;
        assign out3 = y2;
        assign out4 = y3;
    end

endmodule

// File: tb/tb_demux_1to4.sv
module tb_demux_1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_w = '0;
    logic       s0  = 1'b0;
    logic       s1  = 1'b0;

    logic       n1_1, n1_2, n1_3, n1_4;
    logic [7:0] w_1, w_2, w_3, w_4;
    logic [7:0] c_1, c_2, c_3, c_4;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  e_narrow;  // {out4..out1}, WIDTH=1 registered
        logic [31:0] e_wide;    // {out4..out1}, WIDTH=8 registered
        logic [31:0] e_comb;    // {out4..out1}, WIDTH=8 combinational
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    demux_1to4 #(.WIDTH(1), .REG_OUT(1'b1)) dut_n (
        .clk(clk), .rst(rst), .a(a_w[0]), .s0(s0), .s1(s1),
        .out1(n1_1), .out2(n1_2), .out3(n1_3), .out4(n1_4)
    );

    demux_1to4 #(.WIDTH(8), .REG_OUT(1'b1)) dut_w (
        .clk(clk), .rst(rst), .a(a_w), .s0(s0), .s1(s1),
        .out1(w_1), .out2(w_2), .out3(w_3), .out4(w_4)
    );

    demux_1to4 #(.WIDTH(8), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .a(a_w), .s0(s0), .s1(s1),
        .out1(c_1), .out2(c_2), .out3(c_3), .out4(c_4)
    );

    // Reference: output number (2*s1 + s0) carries a, the rest are zero;
    // registered builds are all-zero on a reset cycle.
    function automatic logic [31:0] model(input logic [7:0] a, input int sel, input bit zero);
        logic [7:0] o [4];
        for (int i = 0; i < 4; i++) o[i] = (!zero && i == sel) ? a : 8'h00;
        return {o[3], o[2], o[1], o[0]};
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic step(input bit r, input logic [7:0] a, input bit b1, input bit b0, input string tag);
        exp_t e;
        logic [31:0] wv;
        int sel;
        @(negedge clk);
        rst = r; a_w = a; s1 = b1; s0 = b0;
        sel = 2 * int'(b1) + int'(b0);
        wv = model(a, sel, r);
        e.e_narrow = {wv[24], wv[16], wv[8], wv[0]};
        e.e_wide   = wv;
        e.e_comb   = model(a, sel, 1'b0);
        e.tag      = tag;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            logic [3:0]  gn;
            logic [31:0] gw, gc;
            int nz;
            e  = sb.pop_front();
            gn = {n1_4, n1_3, n1_2, n1_1};
            gw = {w_4, w_3, w_2, w_1};
            gc = {c_4, c_3, c_2, c_1};
            tests++;
            if (gn !== e.e_narrow) begin
                errors++;
                $display("FAIL %s narrow: got %b want %b", e.tag, gn, e.e_narrow);
            end
            tests++;
            if (gw !== e.e_wide) begin
                errors++;
                $display("FAIL %s wide: got %h want %h", e.tag, gw, e.e_wide);
            end
            tests++;
            if (gc !== e.e_comb) begin
                errors++;
                $display("FAIL %s comb: got %h want %h", e.tag, gc, e.e_comb);
            end
            nz = int'(w_1 != 0) + int'(w_2 != 0) + int'(w_3 != 0) + int'(w_4 != 0);
            tests++;
            if (nz > 1) begin
                errors++;
                $display("FAIL %s onehot: got %0d nonzero outputs want <=1", e.tag, nz);
            end
        end
    end

    initial begin
        logic [7:0] r;
        // Reset held with a=1, sel=11, then released.
        step(1'b1, 8'h01, 1'b1, 1'b1, "reset0");
        step(1'b1, 8'h01, 1'b1, 1'b1, "reset1");
        step(1'b0, 8'h01, 1'b1, 1'b1, "release");
        // Select sweep with a nonzero value whose LSB is 1.
        for (int s = 0; s < 4; s++) begin
            r = 8'($urandom) | 8'h01;
            step(1'b0, r, s[1], s[0], "sweep");
        end
        // a = 0 for every select.
        for (int s = 0; s < 4; s++) step(1'b0, 8'h00, s[1], s[0], "azero");
        // Toggle stress: s1 every 5, s0 every 10, a every 20 cycles.
        r = 8'($urandom) | 8'h01;
        for (int c = 0; c < 100; c++)
            step(1'b0, ((c / 20) % 2 == 1) ? r : 8'h00,
                 ((c / 5) % 2) == 1, ((c / 10) % 2) == 1, "toggle");
        // Mid-stream reset pulse.
        step(1'b0, 8'h01, 1'b0, 1'b1, "mid_pre");
        step(1'b1, 8'h01, 1'b0, 1'b1, "mid_rst");
        step(1'b0, 8'h01, 1'b0, 1'b1, "mid_post");
        // Wide value on output 3.
        step(1'b0, 8'hA5, 1'b1, 1'b0, "wideA5");
        // Random traffic with occasional reset.
        for (int c = 0; c < 200; c++)
            step($urandom_range(0, 9) == 0, 8'($urandom), 1'($urandom), 1'($urandom), "random");
        // Drain the scoreboard.
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
